// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Each instruction runs
// through fetch, decode, execute, memory and writeback. Datapath controls are
// a Moore decode of the state. In fetch they are also qualified by mem_ready.
module multicycle_control #(
    parameter int unsigned RA_REG = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] memtoreg,
    output logic [1:0] regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluop,
    output logic [1:0] pcsource,
    output logic       illegal,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeq     = 4'd8,
        StJump    = 4'd9,
        StJal     = 4'd10,
        StAddiEx  = 4'd11,
        StAndiEx  = 4'd12,
        StOriEx   = 4'd13,
        StImmWb   = 4'd14,
        StIllegal = 4'd15
    } state_e;

    state_e state_q, state_d;

    // RA_REG is the datapath's regdst=2 target. It is kept for documentation only.
    logic [4:0] unused_ra_reg;
    assign unused_ra_reg = 5'(RA_REG);

    assign state_o = state_q;

    // State register with synchronous reset to fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Memory states hold until mem_ready is high.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:   if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    6'h00:        state_d = StRtypeEx;
                    6'h23, 6'h2B: state_d = StMemAdr;
                    6'h04:        state_d = StBeq;
                    6'h02:        state_d = StJump;
                    6'h03:        state_d = StJal;
                    6'h08:        state_d = StAddiEx;
                    6'h0C:        state_d = StAndiEx;
                    6'h0D:        state_d = StOriEx;
                    default:      state_d = StIllegal;
                endcase
            end
            StMemAdr:  state_d = (opcode == 6'h23) ? StMemRd : StMemWr;
            StMemRd:   if (mem_ready) state_d = StMemWb;
            StMemWb:   state_d = StFetch;
            StMemWr:   if (mem_ready) state_d = StFetch;
            StRtypeEx: state_d = StRtypeWb;
            StRtypeWb: state_d = StFetch;
            StBeq:     state_d = StFetch;
            StJump:    state_d = StFetch;
            StJal:     state_d = StFetch;
            StAddiEx:  state_d = StImmWb;
            StAndiEx:  state_d = StImmWb;
            StOriEx:   state_d = StImmWb;
            StImmWb:   state_d = StFetch;
            StIllegal: state_d = StFetch;
            default:   state_d = StFetch;
        endcase
    end

    // Output decode. Reset overrides the decode so no write can slip out mid-abort.
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 2'd0;
        regdst      = 2'd0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'd0;
        aluop       = 3'b000;
        pcsource    = 2'd0;
        illegal     = 1'b0;
        unique case (state_q)
            StFetch: begin
                memread = 1'b1;
                alusrcb = 2'd1;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            StDecode:  alusrcb = 2'd3;
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'd2;
            end
            StMemRd: begin
                iord    = 1'b1;
                memread = 1'b1;
            end
            StMemWb: begin
                memtoreg = 2'd1;
                regwrite = 1'b1;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            StRtypeEx: begin
                alusrca = 1'b1;
                aluop   = 3'b010;
            end
            StRtypeWb: begin
                regdst   = 2'd1;
                regwrite = 1'b1;
            end
            StBeq: begin
                alusrca     = 1'b1;
                aluop       = 3'b001;
                pcwritecond = 1'b1;
                pcsource    = 2'd1;
            end
            StJump: begin
                pcwrite  = 1'b1;
                pcsource = 2'd2;
            end
            // The PC already holds PC+4, so the link value is taken straight from the PC.
            StJal: begin
                pcwrite  = 1'b1;
                pcsource = 2'd2;
                regdst   = 2'd2;
                memtoreg = 2'd2;
                regwrite = 1'b1;
            end
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'd2;
            end
            StAndiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'd2;
                aluop   = 3'b011;
            end
            StOriEx: begin
                alusrca = 1'b1;
                alusrcb = 2'd2;
                aluop   = 3'b100;
            end
            StImmWb:   regwrite = 1'b1;
            StIllegal: illegal  = 1'b1;
            default: ;
        endcase
        if (reset) begin
            pcwrite     = 1'b0;
            pcwritecond = 1'b0;
            iord        = 1'b0;
            memread     = 1'b0;
            memwrite    = 1'b0;
            irwrite     = 1'b0;
            memtoreg    = 2'd0;
            regdst      = 2'd0;
            regwrite    = 1'b0;
            alusrca     = 1'b0;
            alusrcb     = 2'd0;
            aluop       = 3'b000;
            pcsource    = 2'd0;
            illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. Each scenario queues per-cycle
// expectations (inputs, state, controls) and replays them against the DUT.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic [1:0] memtoreg, regdst, alusrcb, pcsource;
    logic       regwrite, alusrca, illegal;
    logic [2:0] aluop;
    logic [3:0] state_o;
    logic [19:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic [5:0] op;
        logic [3:0] st;
        logic [19:0] outs;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    multicycle_control #(.RA_REG(31)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsource(pcsource), .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign outs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
                   regwrite, alusrca, alusrcb, aluop, pcsource, illegal};

    // Reference control table, written from the per-state output list.
    function automatic logic [19:0] model_out(input logic rst, input logic rdy,
                                              input logic [3:0] st);
        logic pw, pwc, io, mr, mw, irw, rw, asa, ill;
        logic [1:0] mtr, rd, asb, pcs;
        logic [2:0] aop;
        {pw, pwc, io, mr, mw, irw, rw, asa, ill} = '0;
        {mtr, rd, asb, pcs} = '0;
        aop = 3'b000;
        if (!rst) begin
            case (st)
                4'd0:  begin mr = 1; asb = 2'd1; irw = rdy; pw = rdy; end
                4'd1:  asb = 2'd3;
                4'd2:  begin asa = 1; asb = 2'd2; end
                4'd3:  begin io = 1; mr = 1; end
                4'd4:  begin mtr = 2'd1; rw = 1; end
                4'd5:  begin io = 1; mw = 1; end
                4'd6:  begin asa = 1; aop = 3'b010; end
                4'd7:  begin rd = 2'd1; rw = 1; end
                4'd8:  begin asa = 1; aop = 3'b001; pwc = 1; pcs = 2'd1; end
                4'd9:  begin pw = 1; pcs = 2'd2; end
                4'd10: begin pw = 1; pcs = 2'd2; rd = 2'd2; mtr = 2'd2; rw = 1; end
                4'd11: begin asa = 1; asb = 2'd2; end
                4'd12: begin asa = 1; asb = 2'd2; aop = 3'b011; end
                4'd13: begin asa = 1; asb = 2'd2; aop = 3'b100; end
                4'd14: rw = 1;
                default: ill = 1;
            endcase
        end
        return {pw, pwc, io, mr, mw, irw, mtr, rd, rw, asa, asb, aop, pcs, ill};
    endfunction

    function automatic void push(input logic rst, input logic rdy, input logic [5:0] op,
                                 input logic [3:0] st);
        exp_t x;
        x.rst = rst; x.rdy = rdy; x.op = op; x.st = st;
        x.outs = model_out(rst, rdy, st);
        exp_q.push_back(x);
    endfunction

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b0; opcode = 6'h2B;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (state_o !== 4'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d want 0", state_o);
        end
        n_checks++;
        if (outs !== 20'd0) begin
            n_fail++; $display("FAIL reset_outs: got %h want 00000", outs);
        end
        @(posedge clk); #1;
        // Start a store, stall in MEMWR, then abort with a 2-cycle reset.
        push(0, 1, 6'h2B, 0); push(0, 1, 6'h2B, 1); push(0, 1, 6'h2B, 2);
        push(0, 0, 6'h2B, 5); push(1, 0, 6'h2B, 5); push(1, 0, 6'h2B, 0);
        push(0, 0, 6'h2B, 0); push(0, 1, 6'h2B, 0); push(0, 1, 6'h2B, 1);
        push(0, 1, 6'h2B, 2); push(0, 1, 6'h2B, 5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            reset = e.rst; mem_ready = e.rdy; opcode = e.op;
            @(negedge clk);
            n_checks++;
            if (state_o !== e.st) begin
                n_fail++; $display("FAIL rst_abort_state: got %0d want %0d", state_o, e.st);
            end
            n_checks++;
            if (outs !== e.outs) begin
                n_fail++; $display("FAIL rst_abort_outs: got %h want %h (st %0d)", outs, e.outs, e.st);
            end
            if (e.rst) begin
                n_checks++;
                if (memwrite !== 1'b0) begin
                    n_fail++; $display("FAIL rst_memwrite: got %b want 0", memwrite);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw();
        int rw_bad = 0;
        push(0, 1, 6'h23, 0); push(0, 1, 6'h23, 1); push(0, 1, 6'h23, 2);
        push(0, 1, 6'h23, 3); push(0, 1, 6'h23, 4); push(0, 0, 6'h23, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            reset = e.rst; mem_ready = e.rdy; opcode = e.op;
            @(negedge clk);
            n_checks++;
            if (state_o !== e.st) begin
                n_fail++; $display("FAIL lw_state: got %0d want %0d", state_o, e.st);
            end
            n_checks++;
            if (outs !== e.outs) begin
                n_fail++; $display("FAIL lw_outs: got %h want %h (st %0d)", outs, e.outs, e.st);
            end
            if (regwrite !== (e.st == 4'd4)) rw_bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (rw_bad !== 0) begin
            n_fail++; $display("FAIL lw_regwrite_only_st4: got %0d bad cycles want 0", rw_bad);
        end
    endtask

    task automatic test_sw_stall();
        int mw_cycles = 0;
        int rw_seen = 0;
        push(0, 1, 6'h2B, 0); push(0, 1, 6'h2B, 1); push(0, 1, 6'h2B, 2);
        push(0, 0, 6'h2B, 5); push(0, 0, 6'h2B, 5); push(0, 0, 6'h2B, 5);
        push(0, 1, 6'h2B, 5); push(0, 0, 6'h2B, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            reset = e.rst; mem_ready = e.rdy; opcode = e.op;
            @(negedge clk);
            n_checks++;
            if (state_o !== e.st) begin
                n_fail++; $display("FAIL sw_state: got %0d want %0d", state_o, e.st);
            end
            n_checks++;
            if (outs !== e.outs) begin
                n_fail++; $display("FAIL sw_outs: got %h want %h (st %0d)", outs, e.outs, e.st);
            end
            if (memwrite === 1'b1 && iord === 1'b1) mw_cycles++;
            if (regwrite !== 1'b0) rw_seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (mw_cycles !== 4) begin
            n_fail++; $display("FAIL sw_memwrite_cycles: got %0d want 4", mw_cycles);
        end
        n_checks++;
        if (rw_seen !== 0) begin
            n_fail++; $display("FAIL sw_no_regwrite: got %0d cycles want 0", rw_seen);
        end
    endtask

    task automatic test_rtype_ori();
        push(0, 1, 6'h00, 0); push(0, 1, 6'h00, 1); push(0, 1, 6'h00, 6); push(0, 1, 6'h00, 7);
        push(0, 1, 6'h0D, 0); push(0, 1, 6'h0D, 1); push(0, 1, 6'h0D, 13); push(0, 1, 6'h0D, 14);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            reset = e.rst; mem_ready = e.rdy; opcode = e.op;
            @(negedge clk);
            n_checks++;
            if (state_o !== e.st) begin
                n_fail++; $display("FAIL rt_ori_state: got %0d want %0d", state_o, e.st);
            end
            n_checks++;
            if (outs !== e.outs) begin
                n_fail++; $display("FAIL rt_ori_outs: got %h want %h (st %0d)", outs, e.outs, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_imm_stall();
        // Fetch stalls twice before addi, then andi back to back.
        push(0, 0, 6'h08, 0); push(0, 0, 6'h08, 0); push(0, 1, 6'h08, 0);
        push(0, 1, 6'h08, 1); push(0, 0, 6'h08, 11); push(0, 0, 6'h08, 14);
        push(0, 1, 6'h0C, 0); push(0, 1, 6'h0C, 1); push(0, 1, 6'h0C, 12); push(0, 1, 6'h0C, 14);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            reset = e.rst; mem_ready = e.rdy; opcode = e.op;
            @(negedge clk);
            n_checks++;
            if (state_o !== e.st) begin
                n_fail++; $display("FAIL imm_state: got %0d want %0d", state_o, e.st);
            end
            n_checks++;
            if (outs !== e.outs) begin
                n_fail++; $display("FAIL imm_outs: got %h want %h (st %0d)", outs, e.outs, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq_jal();
        push(0, 1, 6'h04, 0); push(0, 1, 6'h04, 1); push(0, 1, 6'h04, 8);
        push(0, 1, 6'h03, 0); push(0, 1, 6'h03, 1); push(0, 1, 6'h03, 10);
        push(0, 1, 6'h02, 0); push(0, 1, 6'h02, 1); push(0, 1, 6'h02, 9);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            reset = e.rst; mem_ready = e.rdy; opcode = e.op;
            @(negedge clk);
            n_checks++;
            if (state_o !== e.st) begin
                n_fail++; $display("FAIL br_jmp_state: got %0d want %0d", state_o, e.st);
            end
            n_checks++;
            if (outs !== e.outs) begin
                n_fail++; $display("FAIL br_jmp_outs: got %h want %h (st %0d)", outs, e.outs, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        int ill_cycles = 0;
        int wr_seen = 0;
        push(0, 1, 6'h3F, 0); push(0, 1, 6'h3F, 1); push(0, 1, 6'h3F, 15);
        push(0, 0, 6'h3F, 0); push(0, 0, 6'h3F, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            reset = e.rst; mem_ready = e.rdy; opcode = e.op;
            @(negedge clk);
            n_checks++;
            if (state_o !== e.st) begin
                n_fail++; $display("FAIL ill_state: got %0d want %0d", state_o, e.st);
            end
            n_checks++;
            if (outs !== e.outs) begin
                n_fail++; $display("FAIL ill_outs: got %h want %h (st %0d)", outs, e.outs, e.st);
            end
            if (illegal === 1'b1) ill_cycles++;
            if (e.st != 4'd0 && (regwrite | memwrite | pcwrite | pcwritecond | irwrite) !== 1'b0)
                wr_seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (ill_cycles !== 1) begin
            n_fail++; $display("FAIL ill_pulse_len: got %0d want 1", ill_cycles);
        end
        n_checks++;
        if (wr_seen !== 0) begin
            n_fail++; $display("FAIL ill_no_writes: got %0d cycles want 0", wr_seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b0; opcode = 6'h00;
        test_reset();
        test_lw();
        test_sw_stall();
        test_rtype_ori();
        test_imm_stall();
        test_beq_jal();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. Each step is one or more clock cycles. The block drives all datapath mux selects and write enables, and it drives the 3-bit `aluop` consumed by the ALU control decoder. Memory accesses stall on a ready handshake. The FSM also flags unsupported opcodes.

## Interface

Parameters:
- `RA_REG`, default 31: register index written by `jal`. This block does not use it internally; it documents the datapath's regdst=2 target.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `opcode` input 6: IR[31:26]. The datapath holds it stable from DECODE onward.
- `mem_ready` input 1: memory completes the current read/write this cycle.
- `pcwrite` output 1: unconditional PC write.
- `pcwritecond` output 1: PC write if ALU zero (beq).
- `iord` output 1: memory address select, 0=PC, 1=ALUOut.
- `memread` output 1: memory read request.
- `memwrite` output 1: memory write request.
- `irwrite` output 1: load instruction register.
- `memtoreg` output 2: writeback data select, 0=ALUOut, 1=MDR, 2=PC.
- `regdst` output 2: destination register select, 0=rt, 1=rd, 2=`RA_REG`.
- `regwrite` output 1: register file write.
- `alusrca` output 1: ALU operand A select, 0=PC, 1=A.
- `alusrcb` output 2: ALU operand B select, 0=B, 1=4, 2=signext, 3=signext<<2.
- `aluop` output 3: 000 add, 001 sub, 010 R-type(funct), 011 and, 100 or.
- `pcsource` output 2: next-PC select, 0=ALU, 1=ALUOut, 2=jump target.
- `illegal` output 1: one-cycle pulse on an unsupported opcode.
- `state_o` output 4: current state encoding, for debug and verification.

## Operation

- Moore FSM with a registered 4-bit state. Outputs decode combinationally from the state, qualified by `mem_ready` where noted.
- Any output not listed for a state is 0.
- State encodings and per-state outputs:
  - FETCH (0): iord=0, memread=1, alusrca=0, alusrcb=1, aluop=000, pcsource=0. irwrite and pcwrite are asserted only when `mem_ready`=1. Stays in FETCH until `mem_ready`, then goes to DECODE.
  - DECODE (1): alusrca=0, alusrcb=3, aluop=000 (branch target precompute). Next state by `opcode`:
    - 0x00 → RTYPE_EX
    - 0x23 or 0x2B → MEMADR
    - 0x04 → BEQ
    - 0x02 → JUMP
    - 0x03 → JAL
    - 0x08 → ADDI_EX
    - 0x0C → ANDI_EX
    - 0x0D → ORI_EX
    - any other opcode → ILLEGAL
  - MEMADR (2): alusrca=1, alusrcb=2, aluop=000. Goes to MEMRD if opcode=0x23, else to MEMWR.
  - MEMRD (3): iord=1, memread=1. Waits for `mem_ready`, then goes to MEMWB.
  - MEMWB (4): regdst=0, memtoreg=1, regwrite=1. Goes to FETCH.
  - MEMWR (5): iord=1, memwrite=1. Waits for `mem_ready`, then goes to FETCH.
  - RTYPE_EX (6): alusrca=1, alusrcb=0, aluop=010. Goes to RTYPE_WB.
  - RTYPE_WB (7): regdst=1, memtoreg=0, regwrite=1. Goes to FETCH.
  - BEQ (8): alusrca=1, alusrcb=0, aluop=001, pcwritecond=1, pcsource=1. Goes to FETCH.
  - JUMP (9): pcwrite=1, pcsource=2. Goes to FETCH.
  - JAL (10): pcwrite=1, pcsource=2, regdst=2, memtoreg=2, regwrite=1. Goes to FETCH. The PC already holds PC+4 from FETCH.
  - ADDI_EX (11): alusrca=1, alusrcb=2, aluop=000. Goes to IMM_WB.
  - ANDI_EX (12): alusrca=1, alusrcb=2, aluop=011. Goes to IMM_WB.
  - ORI_EX (13): alusrca=1, alusrcb=2, aluop=100. Goes to IMM_WB.
  - IMM_WB (14): regdst=0, memtoreg=0, regwrite=1. Goes to FETCH.
  - ILLEGAL (15): illegal=1 for one cycle, no writes. Goes to FETCH; the instruction executes as a no-op.
- `jr` is an R-type instruction. It flows through RTYPE_EX and RTYPE_WB; the ALU control decoder's jumpreg overrides the PC. This block does not special-case it.
- `memread` and `memwrite` are never asserted in the same cycle.

## Timing

- Reset: when `reset`=1 at a rising edge, state becomes FETCH.
- While `reset` is high, every output is forced to 0 combinationally, regardless of state. This includes `pcwrite`, `regwrite`, `memwrite` and `illegal`; `state_o` still reflects the register.
- Reset mid-instruction (e.g. in MEMWR with `mem_ready` low) aborts the instruction. The next cycle after reset deasserts is FETCH.
- Cycles per instruction with `mem_ready` tied to 1:
  - lw: 5
  - sw, R-type, addi, andi, ori: 4
  - beq, j, jal, illegal: 3
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Request outputs (memread/memwrite, iord) hold steady throughout the stall.
- `mem_ready` sampled in any other state is ignored.
- In FETCH, irwrite and pcwrite assert in the same cycle as `mem_ready`. They are never asserted on a stalled cycle.

## Test plan

- Reset held 2 cycles while state=MEMWR and `mem_ready`=0: memwrite=0 during reset; state_o=0 on the first cycle after release; memread=1.
- opcode=0x23, `mem_ready`=1: state_o sequence is 0,1,2,3,4,0. regwrite=1 only in state 4, with memtoreg=1 and regdst=0.
- opcode=0x2B, `mem_ready` low for 3 cycles in MEMWR: memwrite=1 and iord=1 for 4 cycles; then FETCH; regwrite never asserted.
- opcode=0x00, then 0x0D: R-type shows aluop=010 in state 6 and regdst=1 in state 7. ori shows aluop=100 in state 13 and regwrite=1 in state 14.
- opcode=0x04, then 0x03: BEQ has pcwritecond=1, aluop=001, pcsource=1. JAL has pcwrite=1, pcsource=2, regdst=2, memtoreg=2, regwrite=1. Each completes in 3 cycles.
- opcode=0x3F: illegal=1 for exactly one cycle in state 15; no write enables asserted; returns to FETCH.
